// File: rtl/cmp_pkg.sv
// Shared types and verdict encodings for the serial magnitude comparator.
// Verdicts are one-hot {a_greater, equal, b_greater}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_t;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    // One-hot unsigned verdict for a single 2-bit digit pair.
    function automatic logic [2:0] digit_verdict(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] v;
        if (a > b) begin
            v = CMP_GT;
        end else if (a < b) begin
            v = CMP_LT;
        end else begin
            v = CMP_EQ;
        end
        return v;
    endfunction

endpackage

// File: rtl/cmp_digit_2bit.sv
// Combinational 2-bit unsigned digit comparator with one-hot gt/eq/lt outputs.
module cmp_digit_2bit
    import cmp_pkg::*;
(
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);

    logic [2:0] w_verdict;

    assign w_verdict = digit_verdict(i_a, i_b);
    assign o_gt      = w_verdict[2];
    assign o_eq      = w_verdict[1];
    assign o_lt      = w_verdict[0];

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first magnitude comparator over 2-bit digits with valid/ready in and out.
// Define CMP_SIGNED_EN to treat operands as two's-complement (top digit sign bit inverted).
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_greater,
    output logic             equal,
    output logic             b_greater,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    cmp_state_t       r_state;
    cmp_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [2:0]       r_verdict;
    logic [2:0]       w_verdict_next;

    logic [1:0]       w_a_digits [DIGITS];
    logic [1:0]       w_b_digits [DIGITS];
    logic [1:0]       w_msb_flip;
    logic [1:0]       w_a_digit;
    logic [1:0]       w_b_digit;
    logic             w_dig_gt;
    logic             w_dig_eq;
    logic             w_dig_lt;

    // Slice the captured operands into digits so the active one is a plain array index.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
        assign w_a_digits[gi] = r_a[2*gi +: 2];
        assign w_b_digits[gi] = r_b[2*gi +: 2];
    end

`ifdef CMP_SIGNED_EN
    // Inverting the sign bit of the top digit turns a signed compare into an unsigned one.
    assign w_msb_flip = (r_idx == IDX_TOP) ? 2'b10 : 2'b00;
`else
    assign w_msb_flip = 2'b00;
`endif

    assign w_a_digit = w_a_digits[r_idx] ^ w_msb_flip;
    assign w_b_digit = w_b_digits[r_idx] ^ w_msb_flip;

    cmp_digit_2bit u_digit (
        .i_a  (w_a_digit),
        .i_b  (w_b_digit),
        .o_gt (w_dig_gt),
        .o_eq (w_dig_eq),
        .o_lt (w_dig_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_verdict <= CMP_NONE;
        end else begin
            r_state   <= w_state_next;
            r_a       <= w_a_next;
            r_b       <= w_b_next;
            r_idx     <= w_idx_next;
            r_verdict <= w_verdict_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_a_next       = r_a;
        w_b_next       = r_b;
        w_idx_next     = r_idx;
        w_verdict_next = r_verdict;

        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_a_next       = a;
                    w_b_next       = b;
                    w_idx_next     = IDX_TOP;
                    w_verdict_next = CMP_NONE;
                    w_state_next   = COMPARE;
                end
            end
            COMPARE: begin
                if (!w_dig_eq) begin
                    w_verdict_next = {w_dig_gt, 1'b0, w_dig_lt};
                    w_state_next   = DONE;
                end else if (r_idx == '0) begin
                    w_verdict_next = CMP_EQ;
                    w_state_next   = DONE;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_verdict_next = CMP_NONE;
                    w_state_next   = IDLE;
                end
            end
            default: begin
                w_verdict_next = CMP_NONE;
                w_state_next   = IDLE;
            end
        endcase
    end

    // The verdict register is only non-zero in DONE, so flags are never seen without out_valid.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == COMPARE) || (r_state == DONE);
    assign a_greater = r_verdict[2];
    assign equal     = r_verdict[1];
    assign b_greater = r_verdict[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH=8).
// Expectations for the FF/01 and 00/FF vectors follow CMP_SIGNED_EN when defined.
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;
    localparam logic [2:0] V_GT = 3'b100;
    localparam logic [2:0] V_EQ = 3'b010;
    localparam logic [2:0] V_LT = 3'b001;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             a_greater;
    logic             equal;
    logic             b_greater;
    logic             busy;

    int n_checks;
    int n_fails;

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_greater (a_greater),
        .equal     (equal),
        .b_greater (b_greater),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Drive one operand pair for a single accepting edge.
    task automatic offer(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
    endtask

    // Count edges from the accepting edge until out_valid; then check latency and verdict.
    task automatic wait_verdict(input int exp_n, input logic [2:0] exp_v, input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            check({tag, ".in_ready_busy"}, {in_ready, busy}, 2'b01);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, n, exp_n);
        check({tag, ".verdict"}, {a_greater, equal, b_greater}, exp_v);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #1;
        check("reset.outputs", {out_valid, a_greater, equal, b_greater, busy}, 5'b0);
        check("reset.in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        offer(8'hC3, 8'h83, "gt_top");
        wait_verdict(1, V_GT, "gt_top");
        @(posedge clk); #1;
        check("gt_top.release", {out_valid, a_greater, in_ready}, 3'b001);

        offer(8'h5A, 8'h5A, "eq");
        wait_verdict(4, V_EQ, "eq");
        @(posedge clk); #1;

        offer(8'h12, 8'h13, "lt_lsd");
        wait_verdict(4, V_LT, "lt_lsd");
        @(posedge clk); #1;

        // Back-pressure: verdict must hold while out_ready is low.
        out_ready = 1'b0;
        offer(8'hC3, 8'h83, "hold");
        wait_verdict(1, V_GT, "hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold.stable", {out_valid, a_greater, equal, b_greater, in_ready}, 5'b11000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h5A;
        b         = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold.consumed", {out_valid, a_greater, equal, b_greater, busy}, 5'b0);
        check("hold.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check("hold.no_bypass", {in_ready, busy}, 2'b10);

        // Reset in the middle of a comparison.
        offer(8'h12, 8'h13, "abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.outputs", {out_valid, a_greater, equal, b_greater, busy}, 5'b0);
        check("abort.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        offer(8'h01, 8'h00, "after_rst");
        wait_verdict(4, V_GT, "after_rst");
        @(posedge clk); #1;

        offer(8'hFF, 8'h01, "sign_ff_01");
`ifdef CMP_SIGNED_EN
        wait_verdict(1, V_LT, "sign_ff_01");
`else
        wait_verdict(1, V_GT, "sign_ff_01");
`endif
        @(posedge clk); #1;

        offer(8'h00, 8'hFF, "sign_00_ff");
`ifdef CMP_SIGNED_EN
        wait_verdict(1, V_GT, "sign_00_ff");
`else
        wait_verdict(1, V_LT, "sign_00_ff");
`endif
        @(posedge clk); #1;

        offer(8'h00, 8'h00, "eq_zero");
        wait_verdict(4, V_EQ, "eq_zero");
        @(posedge clk); #1;
        check("final.idle", {in_ready, busy, out_valid}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Sequential wide-operand magnitude comparator for the comparator datapath.
- Accepts WIDTH-bit operands A and B over a valid/ready handshake.
- Compares them as 2-bit digit pairs, MSB digit first, one digit per clock, stopping at the first unequal digit.
- Presents a registered one-hot verdict (a_greater / equal / b_greater) over a second valid/ready handshake for the consuming stage.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- DIGITS, WIDTH/2, localparam; number of 2-bit digits (not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A; sampled on the input handshake.
- b  input  WIDTH  operand B; sampled on the input handshake.
- out_valid  output  1  verdict valid; high only in DONE.
- out_ready  input  1  consumer accepts the verdict.
- a_greater  output  1  A > B.
- equal  output  1  A == B.
- b_greater  output  1  A < B.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; operand and index registers = 0.
  - out_valid, a_greater, equal, b_greater, busy = 0; in_ready = 1.
  - Reset mid-operation abandons the comparison with no output handshake.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a and b, set idx = DIGITS-1, go to COMPARE.
  - in_valid without a handshake has no effect.
- COMPARE (in_ready = 0, busy = 1): each cycle compare digit {a[2*idx+1], a[2*idx]} against the same digit of b.
  - Digits unequal: latch the verdict flag, go to DONE.
  - Digits equal and idx == 0: latch equal, go to DONE.
  - Otherwise: idx decrements; stay in COMPARE.
- DONE:
  - out_valid = 1; exactly one verdict flag is high; flags and out_valid are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid and all flags drop to 0 on that edge.
  - in_ready returns to 1 in the following cycle. No bypass: new operands cannot be accepted in the same cycle as the result is consumed.
- Latency:
  - out_valid rises n rising edges after the accepting edge, where n = number of digits examined (1..DIGITS).
  - Equal operands: n = DIGITS.
  - Throughput: at most one comparison per n+2 cycles.
- Verdict flags are 0 whenever out_valid = 0.
- Digit compare is unsigned 2-bit unless the optional feature below is enabled.
- Operand inputs are ignored outside IDLE; input changes during COMPARE do not affect the result.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined: operands are two's-complement. When idx == DIGITS-1, the top bit of both digits is inverted before the compare. All other digits compare unsigned.
- Undefined: all digits compare unsigned.
- Timing and handshakes are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - state enum typedef cmp_state_t {IDLE, COMPARE, DONE}.
  - Verdict encoding constants CMP_GT, CMP_EQ, CMP_LT as a 3-bit one-hot {a_greater, equal, b_greater}.
- Sub-module cmp_digit_2bit: purely combinational; 2-bit a and b in, one-hot gt/eq/lt out. Instantiated once, fed by the idx-selected digit slices.
- Handshake, FSM and index counter stay in the top module.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- a=8'hC3, b=8'h83, in_valid for one cycle -> top digit 11 vs 10; out_valid one edge after accept with a_greater=1, equal=0, b_greater=0.
- a=8'h5A, b=8'h5A -> out_valid 4 edges after accept with equal=1; in_ready=0 throughout COMPARE.
- a=8'h12, b=8'h13 -> digits equal until idx 0; b_greater=1 after 4 edges.
- a=8'hC3, b=8'h83, out_ready=0 for 5 cycles -> out_valid and a_greater stay stable; in_ready=0. Then out_ready=1 -> out_valid=0 after that edge and in_ready=1; a fresh in_valid offered in the handshake cycle is not accepted.
- Accept a=8'h12, b=8'h13; assert rst_n low 2 edges later -> all outputs 0 and in_ready=1 immediately. After release, accept a=8'h01, b=8'h00 -> a_greater after 4 edges.
- a=8'hFF, b=8'h01:
  - With CMP_SIGNED_EN -> b_greater after 1 edge (-1 < 1).
  - Without the macro -> a_greater after 1 edge.
